// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-logic back end.
//   sc_state_e             : decoder FSM states (2-bit encoding)
//   SC_WINDOW_LOG2_DEFAULT : default log2 window length, also used by the
//                            upstream random-source and select blocks
package sc_pkg;

    localparam int unsigned SC_WINDOW_LOG2_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } sc_state_e;

endpackage

// File: rtl/sc_window_ctr.sv
// Valid-sample counter for one decoding window.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the sample count (start of a new window)
//   advance  : count one valid sample this cycle
//   at_last  : the count equals 2**WINDOW_LOG2-1, so the next valid sample
//              completes the window
module sc_window_ctr #(
    parameter int unsigned WINDOW_LOG2 = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic at_last
);

    localparam logic [WINDOW_LOG2:0] TERMINAL = {1'b0, {WINDOW_LOG2{1'b1}}};

    logic [WINDOW_LOG2:0] sample_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (clear) begin
            sample_cnt <= '0;
        end else if (advance) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    assign at_last = (sample_cnt == TERMINAL);

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones in a window of 2**WINDOW_LOG2
// valid samples and offers the count through a valid/ready handshake.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   start         : begin a window (IDLE, or HOLD together with handshake)
//   bit_in        : stochastic bit, counted only when bit_valid is high
//   bit_valid     : bit_in is a sample this cycle
//   busy          : high in ACCUM and HOLD
//   result        : ones count of the last completed window (0..2**WINDOW_LOG2)
//   result_valid  : result is offered (HOLD)
//   result_ready  : consumer accepts result
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = SC_WINDOW_LOG2_DEFAULT,
    parameter int unsigned OUT_W       = WINDOW_LOG2 + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    sc_state_e        state, state_next;
    logic [OUT_W-1:0] ones_cnt, ones_next;
    logic [OUT_W-1:0] result_next;
    logic             ctr_clear;
    logic             ctr_advance;
    logic             at_last;
    logic [OUT_W-1:0] ones_plus;

    sc_window_ctr #(
        .WINDOW_LOG2(WINDOW_LOG2)
    ) u_window_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .advance (ctr_advance),
        .at_last (at_last)
    );

    // Only consumed when bit_valid is high, so an undefined bit_in in a
    // gap cycle never reaches the registers.
    assign ones_plus = ones_cnt + {{(OUT_W-1){1'b0}}, bit_in};

    always_comb begin
        state_next  = state;
        ones_next   = ones_cnt;
        result_next = result;
        ctr_clear   = 1'b0;
        ctr_advance = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                    ctr_clear  = 1'b1;
                    ones_next  = '0;
                end
            end
            ACCUM: begin
                if (bit_valid) begin
                    ctr_advance = 1'b1;
                    ones_next   = ones_plus;
                    // The final sample goes straight into result so the
                    // count is offered on the very next edge.
                    if (at_last) begin
                        result_next = ones_plus;
                        state_next  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (result_ready) begin
                    if (start) begin
                        state_next = ACCUM;
                        ctr_clear  = 1'b1;
                        ones_next  = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ones_cnt <= '0;
            result   <= '0;
        end else begin
            state    <= state_next;
            ones_cnt <= ones_next;
            result   <= result_next;
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == HOLD);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder with an 8-sample window.
module tb_sc_stream_decoder;

    localparam int unsigned WL2 = 3;
    localparam int unsigned OW  = WL2 + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          busy;
    logic [OW-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    sc_stream_decoder #(
        .WINDOW_LOG2(WL2),
        .OUT_W      (OW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0]  bits;      // sample i is bits[i]
        int unsigned gap_mode;  // 0 none, 1 gap before odd samples, 3 start poke
        logic [3:0]  exp;
        int unsigned hold;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Drives 8 valid samples (mode 2 adds random gaps with junk bit_in).
    task automatic feed(input logic [7:0] bits, input int unsigned mode,
                        input logic [3:0] exp, input string name);
        logic bad;
        int unsigned g;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mode == 1 && (i % 2) == 1) begin
                bit_valid = 1'b0;
                bit_in    = 1'b1;
                tick;
                if (result_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            end
            if (mode == 2) begin
                g = 0;
                while (g < 4 && $urandom_range(0, 2) == 0) begin
                    bit_valid = 1'b0;
                    bit_in    = ($urandom_range(0, 1) == 1) ? 1'bx : 1'b1;
                    tick;
                    if (result_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
                    g++;
                end
            end
            bit_valid = 1'b1;
            bit_in    = bits[i];
            start     = (mode == 3 && i == 3);
            tick;
            bit_valid = 1'b0;
            start     = 1'b0;
            if (i < 7 && (result_valid !== 1'b0 || busy !== 1'b1)) bad = 1'b1;
        end
        check({name, "_accum_flags"}, {31'd0, bad}, 32'd0);
        check({name, "_valid"}, {31'd0, result_valid}, 32'd1);
        check({name, "_result"}, {28'd0, result}, {28'd0, exp});
    endtask

    task automatic hold_release(input logic [3:0] exp, input int unsigned n_hold,
                                input logic poke, input logic restart, input string name);
        logic bad;
        bad = 1'b0;
        result_ready = 1'b0;
        for (int k = 0; k < int'(n_hold); k++) begin
            start = poke && (k == 1);
            tick;
            start = 1'b0;
            if (result_valid !== 1'b1 || result !== exp || busy !== 1'b1) bad = 1'b1;
        end
        check({name, "_hold"}, {31'd0, bad}, 32'd0);
        result_ready = 1'b1;
        start        = restart;
        tick;
        result_ready = 1'b0;
        start        = 1'b0;
        check({name, "_after_valid"}, {31'd0, result_valid}, 32'd0);
        check({name, "_after_busy"}, {31'd0, busy}, {31'd0, restart});
    endtask

    vec_t vecs[7];

    initial begin
        logic [7:0]  rbits;
        logic [3:0]  rexp;
        logic        in_accum;
        logic        restart;
        int unsigned q[$];

        vecs[0] = '{bits: 8'b0100_1101, gap_mode: 0, exp: 4'd4, hold: 5};
        vecs[1] = '{bits: 8'hFF,        gap_mode: 1, exp: 4'd8, hold: 2};
        vecs[2] = '{bits: 8'h00,        gap_mode: 0, exp: 4'd0, hold: 1};
        vecs[3] = '{bits: 8'h80,        gap_mode: 0, exp: 4'd1, hold: 1};
        vecs[4] = '{bits: 8'h01,        gap_mode: 1, exp: 4'd1, hold: 1};
        vecs[5] = '{bits: 8'hAA,        gap_mode: 3, exp: 4'd4, hold: 3};
        vecs[6] = '{bits: 8'hFE,        gap_mode: 0, exp: 4'd7, hold: 1};

        // Power-on reset
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result", {28'd0, result}, 32'd0);

        // Leave a nonzero result, then reset in the middle of a window
        do_start;
        feed(8'hFF, 0, 4'd8, "pre_rst");
        hold_release(4'd8, 1, 1'b0, 1'b0, "pre_rst");
        do_start;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick;
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, result_valid}, 32'd0);
        check("midrst_result", {28'd0, result}, 32'd0);
        // Valid samples in IDLE are ignored; the partial count is gone
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick;
        bit_valid = 1'b0;
        check("idle_ignores_busy", {31'd0, busy}, 32'd0);
        do_start;
        feed(8'h00, 0, 4'd0, "post_rst");
        hold_release(4'd0, 1, 1'b0, 1'b0, "post_rst");

        // Table-driven windows
        for (int v = 0; v < 7; v++) begin
            do_start;
            check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd1);
            feed(vecs[v].bits, vecs[v].gap_mode, vecs[v].exp, $sformatf("vec%0d", v));
            hold_release(vecs[v].exp, vecs[v].hold, vecs[v].gap_mode == 3, 1'b0,
                         $sformatf("vec%0d", v));
        end

        // Back-to-back: accept and restart in the same cycle
        do_start;
        feed(8'hFF, 0, 4'd8, "b2b_a");
        hold_release(4'd8, 1, 1'b0, 1'b1, "b2b_a");
        feed(8'h00, 0, 4'd0, "b2b_b");
        hold_release(4'd0, 2, 1'b0, 1'b0, "b2b_b");

        // Random windows against a sample-list reference
        in_accum = 1'b0;
        for (int w = 0; w < 1000; w++) begin
            rbits = 8'($urandom);
            q.delete();
            for (int i = 0; i < 8; i++) q.push_back(int'(rbits[i]));
            rexp = '0;
            foreach (q[i]) rexp = rexp + 4'(q[i]);
            if (!in_accum) do_start;
            feed(rbits, 2, rexp, $sformatf("rnd%0d", w));
            restart = ($urandom_range(0, 1) == 1);
            hold_release(rexp, $urandom_range(0, 2), $urandom_range(0, 1) == 1, restart,
                         $sformatf("rnd%0d", w));
            in_accum = restart;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
